// File: rtl/sarray_seq.sv
// ============================================================================
//  Module   : sarray_seq
//  Purpose  : Sequencer for an HxH systolic array. Accepts one TMMA command,
//             produces skewed per-row/per-column valid and beat-index streams
//             (FEED), waits for the array to drain (DRAIN), then enables
//             result shift-out (STORE) and pulses done.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    H       rows = columns of the array (2..64)
//    CNT_W   K-beat counter width
//    PREC_W  precision field width
//  Ports
//    clk, rst_n                      clock, asynchronous active-low reset
//    cmd_valid_i / cmd_ready_o       command handshake (ready only in IDLE)
//    cmd_k_i, cmd_acc_i,
//    cmd_type_i, cmd_precision_i     command fields, latched on accept
//    abort_i                         abandons a running command
//    left_valid_o/left_cnt_o         per-row skewed valid / beat index
//    left_type_o/left_precision_o    latched type / precision per row
//    left_acc_o                      accumulate flag on each row's first beat
//    top_valid_o/top_cnt_o           per-column copies of the row streams
//    storec_valid_o                  result shift-out enable
//    busy_o, done_o                  status, one-cycle completion pulse
//    cycles_o                        busy-cycle count of the last command
//                                    (only with SARRAY_SEQ_PERF_EN defined)
//  Build option
//    SARRAY_SEQ_PERF_EN  adds cycles_o and its saturating counter
// ============================================================================
`default_nettype none

module sarray_seq #(
  parameter int H      = 64,
  parameter int CNT_W  = 8,
  parameter int PREC_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [CNT_W-1:0]    cmd_k_i,
  input  logic                cmd_acc_i,
  input  logic                cmd_type_i,
  input  logic [PREC_W-1:0]   cmd_precision_i,
  input  logic                abort_i,
  output logic [H-1:0]        left_valid_o,
  output logic [CNT_W*H-1:0]  left_cnt_o,
  output logic [H-1:0]        left_type_o,
  output logic [PREC_W*H-1:0] left_precision_o,
  output logic [H-1:0]        left_acc_o,
  output logic [H-1:0]        top_valid_o,
  output logic [CNT_W*H-1:0]  top_cnt_o,
  output logic                storec_valid_o,
  output logic                busy_o,
  output logic                done_o
`ifdef SARRAY_SEQ_PERF_EN
  ,
  output logic [31:0]         cycles_o
`endif
);

  // Phase counter is wide enough for K+H-2 at maximum K, so it never wraps.
  localparam int T_W = CNT_W + $clog2(H) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_STORE = 2'd3;

  localparam logic [T_W-1:0] c_HM1 = T_W'(H - 1);
  localparam logic [T_W-1:0] c_HM2 = T_W'(H - 2);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [T_W-1:0]     r_t;
  logic [CNT_W-1:0]   r_k;
  logic               r_acc;
  logic               r_type;
  logic [PREC_W-1:0]  r_prec;

  logic [H-1:0]       r_valid;
  logic [CNT_W*H-1:0] r_cnt;
  logic [H-1:0]       r_acc_out;
  logic               r_storec;
  logic               r_busy;
  logic               r_done;
  logic               r_ready;

  // --------------------------------------------------------------------------
  // Wires
  // --------------------------------------------------------------------------
  logic               w_accept;
  logic [1:0]         w_state_nx;
  logic [T_W-1:0]     w_t_nx;
  logic               w_done_nx;
  logic [T_W-1:0]     w_feed_last;
  logic [CNT_W-1:0]   w_k_nx;
  logic [T_W-1:0]     w_k_ext_nx;
  logic               w_acc_nx;
  logic               w_feed_nx;
  logic               w_storec_nx;
  logic               w_busy_nx;
  logic               w_ready_nx;
  logic [H-1:0]       w_valid_nx;
  logic [CNT_W*H-1:0] w_cnt_nx;
  logic [H-1:0]       w_acc_o_nx;

  assign w_accept    = cmd_valid_i && (r_state == S_IDLE);
  assign w_feed_last = {{(T_W-CNT_W){1'b0}}, r_k} + c_HM2;

  // Outputs are registered and must show the values for the state/t being
  // entered, so lane decode works on the next-cycle view of K and acc.
  assign w_k_nx     = w_accept ? cmd_k_i   : r_k;
  assign w_acc_nx   = w_accept ? cmd_acc_i : r_acc;
  assign w_k_ext_nx = {{(T_W-CNT_W){1'b0}}, w_k_nx};

  // --------------------------------------------------------------------------
  // State register (with phase counter and latched command fields)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_k     <= '0;
      r_acc   <= 1'b0;
      r_type  <= 1'b0;
      r_prec  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_t     <= w_t_nx;
      if (w_accept) begin
        r_k    <= cmd_k_i;
        r_acc  <= cmd_acc_i;
        r_type <= cmd_type_i;
        r_prec <= cmd_precision_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. t restarts at 0 on entry to every phase; abort is only
  // honoured outside IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nx = r_state;
    w_t_nx     = r_t;
    w_done_nx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_t_nx = '0;
        if (w_accept) begin
          if (cmd_k_i == '0) w_done_nx  = 1'b1;
          else               w_state_nx = S_FEED;
        end
      end
      S_FEED: begin
        if (abort_i) begin
          w_state_nx = S_IDLE;
          w_t_nx     = '0;
        end else if (r_t == w_feed_last) begin
          w_state_nx = S_DRAIN;
          w_t_nx     = '0;
        end else begin
          w_t_nx = r_t + 1'b1;
        end
      end
      S_DRAIN: begin
        if (abort_i) begin
          w_state_nx = S_IDLE;
          w_t_nx     = '0;
        end else if (r_t == c_HM1) begin
          w_state_nx = S_STORE;
          w_t_nx     = '0;
        end else begin
          w_t_nx = r_t + 1'b1;
        end
      end
      S_STORE: begin
        if (abort_i) begin
          w_state_nx = S_IDLE;
          w_t_nx     = '0;
        end else if (r_t == c_HM1) begin
          w_state_nx = S_IDLE;
          w_t_nx     = '0;
          w_done_nx  = 1'b1;
        end else begin
          w_t_nx = r_t + 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_t_nx     = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode (next-cycle values)
  // --------------------------------------------------------------------------
  always_comb begin
    w_feed_nx   = (w_state_nx == S_FEED);
    w_storec_nx = (w_state_nx == S_STORE);
    w_busy_nx   = (w_state_nx != S_IDLE);
    w_ready_nx  = (w_state_nx == S_IDLE);
  end

  // Lane i sees beat t-i; it is live while 0 <= t-i < K.
  genvar gi;
  generate
    for (gi = 0; gi < H; gi++) begin : g_lane
      localparam logic [T_W-1:0] c_IDX = T_W'(gi);
      logic [T_W-1:0] w_diff;
      logic           w_v;
      assign w_diff = w_t_nx - c_IDX;
      assign w_v    = w_feed_nx && (w_t_nx >= c_IDX) && (w_diff < w_k_ext_nx);
      assign w_valid_nx[gi]              = w_v;
      assign w_cnt_nx[gi*CNT_W +: CNT_W] = w_v ? w_diff[CNT_W-1:0] : '0;
      assign w_acc_o_nx[gi]              = w_acc_nx && w_v && (w_diff == '0);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= '0;
      r_cnt     <= '0;
      r_acc_out <= '0;
      r_storec  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_valid   <= w_valid_nx;
      r_cnt     <= w_cnt_nx;
      r_acc_out <= w_acc_o_nx;
      r_storec  <= w_storec_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
      r_ready   <= w_ready_nx;
    end
  end

  assign cmd_ready_o      = r_ready;
  assign left_valid_o     = r_valid;
  assign left_cnt_o       = r_cnt;
  assign left_acc_o       = r_acc_out;
  assign left_type_o      = {H{r_type}};
  assign left_precision_o = {H{r_prec}};
  assign top_valid_o      = r_valid;
  assign top_cnt_o        = r_cnt;
  assign storec_valid_o   = r_storec;
  assign busy_o           = r_busy;
  assign done_o           = r_done;

`ifdef SARRAY_SEQ_PERF_EN
  // Busy-cycle counter: cleared on accept, holds once IDLE, saturates.
  logic [31:0] r_cycles;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycles <= '0;
    end else if (w_accept) begin
      r_cycles <= '0;
    end else if ((r_state != S_IDLE) && (r_cycles != 32'hFFFF_FFFF)) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end
  assign cycles_o = r_cycles;
`endif

endmodule

`default_nettype wire
